// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter that owns the select of an 8:1 data mux.
// One owner at a time; released on done, dropped request or hold timeout.
module mux8_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic [2:0] sel,
  output logic       sel_valid,
  output logic       timeout
);

  // A zero MAX_HOLD still needs a one-bit counter to keep widths legal.
  localparam int unsigned CNT_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HoldMax = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HoldSat = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    StIdle,
    StOwn,
    StGap
  } state_e;

  state_e           state_q;
  logic [2:0]       last_q;
  logic [CNT_W-1:0] hold_q;

  logic [2:0] win;
  logic       win_found;
  logic [2:0] idx;
  logic       r_done;
  logic       r_drop;
  logic       r_to;
  logic       release_own;

  // Search starts just past the previous winner; the previous winner is tried last.
  always_comb begin
    win       = 3'd0;
    win_found = 1'b0;
    idx       = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      idx = last_q + 3'(k);
      if (!win_found && req[idx]) begin
        win       = idx;
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    r_done      = done;
    r_drop      = !req[sel];
    r_to        = (MAX_HOLD != 0) && (hold_q == HoldMax);
    release_own = r_done || r_drop || r_to;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      last_q    <= 3'd7;
      hold_q    <= '0;
      grant     <= 8'h00;
      sel       <= 3'd0;
      sel_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          timeout <= 1'b0;
          if (win_found) begin
            grant     <= 8'h01 << win;
            sel       <= win;
            sel_valid <= 1'b1;
            last_q    <= win;
            hold_q    <= CNT_W'(1);
            state_q   <= StOwn;
          end else begin
            grant     <= 8'h00;
            sel_valid <= 1'b0;
          end
        end
        StOwn: begin
          if (release_own) begin
            grant     <= 8'h00;
            sel_valid <= 1'b0;
            // A voluntary release on the same edge suppresses the timeout pulse.
            timeout   <= r_to && !r_done && !r_drop;
            state_q   <= StGap;
          end else if (hold_q != HoldSat) begin
            hold_q <= hold_q + 1'b1;
          end
        end
        StGap: begin
          grant     <= 8'h00;
          sel_valid <= 1'b0;
          timeout   <= 1'b0;
          hold_q    <= '0;
          state_q   <= StIdle;
        end
        default: begin
          grant     <= 8'h00;
          sel_valid <= 1'b0;
          timeout   <= 1'b0;
          hold_q    <= '0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter: a per-cycle vector table plus
// hand-written rotation and timeout sequences.
module tb_mux8_rr_arbiter;

  logic       clk;
  logic       rst_a, rst_b;
  logic [7:0] req_a, req_b;
  logic       done_a, done_b;
  logic [7:0] grant_a, grant_b;
  logic [2:0] sel_a, sel_b;
  logic       sv_a, sv_b;
  logic       to_a, to_b;

  int checks = 0;
  int errors = 0;

  mux8_rr_arbiter #(.MAX_HOLD(15)) u_dut_a (
    .clk      (clk),
    .rst      (rst_a),
    .req      (req_a),
    .done     (done_a),
    .grant    (grant_a),
    .sel      (sel_a),
    .sel_valid(sv_a),
    .timeout  (to_a)
  );

  mux8_rr_arbiter #(.MAX_HOLD(4)) u_dut_b (
    .clk      (clk),
    .rst      (rst_b),
    .req      (req_b),
    .done     (done_b),
    .grant    (grant_b),
    .sel      (sel_b),
    .sel_valid(sv_b),
    .timeout  (to_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] g;
    logic [2:0] s;
    logic       v;
    logic       t;
    logic       cs;
  } vec_t;

  vec_t vq[$];

  task automatic addv(input logic r, input logic [7:0] rq, input logic d, input logic [7:0] g,
                      input logic [2:0] s, input logic v, input logic t, input logic cs);
    vec_t x;
    x.rst = r; x.req = rq; x.done = d; x.g = g; x.s = s; x.v = v; x.t = t; x.cs = cs;
    vq.push_back(x);
  endtask

  task automatic chk(input string nm, input int step, input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step %0d got %h want %h", nm, step, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_b(input string nm, input int step, input logic [7:0] g,
                       input logic [2:0] s, input logic v, input logic t);
    chk({nm, ".grant"}, step, grant_b, g);
    chk({nm, ".valid"}, step, {7'd0, sv_b}, {7'd0, v});
    chk({nm, ".timeout"}, step, {7'd0, to_b}, {7'd0, t});
    if (v) chk({nm, ".sel"}, step, {5'd0, sel_b}, {5'd0, s});
  endtask

  initial begin
    rst_a = 1'b1; req_a = 8'h00; done_a = 1'b0;
    rst_b = 1'b1; req_b = 8'h00; done_b = 1'b0;

    //    rst  req    done grant  sel   v     t     cs
    addv(1'b1, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1);  // reset state
    addv(1'b0, 8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0, 1'b1);  // first grant to 0
    addv(1'b0, 8'h01, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);  // done releases
    addv(1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);  // gap
    addv(1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);  // idle, no req
    addv(1'b0, 8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0, 1'b1);  // owner 3
    addv(1'b0, 8'h08, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    addv(1'b0, 8'h09, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);  // gap ignores req
    addv(1'b0, 8'h09, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0, 1'b1);  // wraps 4..7 to 0
    addv(1'b0, 8'h09, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    addv(1'b0, 8'h08, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    addv(1'b0, 8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0, 1'b1);  // then 3
    addv(1'b0, 8'h08, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    addv(1'b0, 8'h20, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    addv(1'b0, 8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0, 1'b1);  // owner 5
    addv(1'b0, 8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0, 1'b1);  // held
    addv(1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);  // drop releases
    addv(1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    addv(1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    addv(1'b0, 8'h40, 1'b0, 8'h40, 3'd6, 1'b1, 1'b0, 1'b1);  // owner 6
    addv(1'b0, 8'h40, 1'b0, 8'h40, 3'd6, 1'b1, 1'b0, 1'b1);
    addv(1'b1, 8'h40, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1);  // reset mid-own
    addv(1'b0, 8'hFF, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0, 1'b1);  // priority restarts at 0
    addv(1'b0, 8'hFF, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    addv(1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    for (int i = 0; i < vq.size(); i++) begin
      rst_a  = vq[i].rst;
      req_a  = vq[i].req;
      done_a = vq[i].done;
      tick();
      chk("tbl.grant", i, grant_a, vq[i].g);
      chk("tbl.valid", i, {7'd0, sv_a}, {7'd0, vq[i].v});
      chk("tbl.timeout", i, {7'd0, to_a}, {7'd0, vq[i].t});
      if (vq[i].cs) chk("tbl.sel", i, {5'd0, sel_a}, {5'd0, vq[i].s});
    end

    // Full rotation with all requesting: 0..7 then 0, two low cycles between owners.
    rst_a = 1'b1; req_a = 8'h00; done_a = 1'b0;
    tick();
    rst_a = 1'b0; req_a = 8'hFF;
    for (int n = 0; n < 9; n++) begin
      logic [2:0] exp_s;
      exp_s = 3'(n);
      done_a = 1'b0;
      tick();
      chk("rot.grant", n, grant_a, 8'h01 << exp_s);
      chk("rot.sel", n, {5'd0, sel_a}, {5'd0, exp_s});
      chk("rot.valid", n, {7'd0, sv_a}, 8'h01);
      done_a = 1'b1;
      tick();
      chk("rot.rel", n, grant_a, 8'h00);
      done_a = 1'b0;
      tick();
      chk("rot.gap", n, grant_a, 8'h00);
    end

    // Timeout with MAX_HOLD=4.
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0; req_b = 8'h04; done_b = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_b("to.hold", c, 8'h04, 3'd2, 1'b1, 1'b0);
    end
    tick();
    chk_b("to.evict", 0, 8'h00, 3'd0, 1'b0, 1'b1);
    tick();
    chk_b("to.gap", 0, 8'h00, 3'd0, 1'b0, 1'b0);
    tick();
    chk_b("to.regrant", 0, 8'h04, 3'd2, 1'b1, 1'b0);
    req_b = 8'h14;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_b("to.hold2", c, 8'h04, 3'd2, 1'b1, 1'b0);
    end
    tick();
    chk_b("to.evict2", 0, 8'h00, 3'd0, 1'b0, 1'b1);
    tick();
    chk_b("to.gap2", 0, 8'h00, 3'd0, 1'b0, 1'b0);
    tick();
    chk_b("to.next4", 0, 8'h10, 3'd4, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_b("to.hold4", c, 8'h10, 3'd4, 1'b1, 1'b0);
    end
    // done coincides with the hold limit: release without timeout.
    done_b = 1'b1;
    tick();
    chk_b("to.done_wins", 0, 8'h00, 3'd0, 1'b0, 1'b0);
    done_b = 1'b0;
    tick();
    chk_b("to.gap3", 0, 8'h00, 3'd0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
